// File: rtl/edge_enhance_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : edge_enhance_frame_ctrl_if
// Brief    : AXI-Stream style pixel input bundle (valid/ready plus frame
//            markers) feeding the edge-enhancement frame sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface edge_enhance_frame_ctrl_if;
  logic s_tvalid;
  logic s_tuser;
  logic s_tlast;
  logic s_tready;

  // Pixel source side
  modport master (
    output s_tvalid,
    output s_tuser,
    output s_tlast,
    input  s_tready
  );

  // Frame sequencer side
  modport slave (
    input  s_tvalid,
    input  s_tuser,
    input  s_tlast,
    output s_tready
  );
endinterface
`default_nettype wire

// File: rtl/edge_enhance_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : edge_enhance_frame_ctrl
// Brief    : Frame sequencer for the edge-enhancement pipeline. Shadows the
//            configuration at start-of-frame, gates the input stream, tracks
//            pixel position, flags full 3x3 windows, flushes the datapath at
//            end of frame and records sticky framing errors.
// Revision : 1.0 - initial release
// ============================================================================
module edge_enhance_frame_ctrl #(
  parameter int DIM_W    = 12,
  parameter int GAIN_W   = 8,
  parameter int PIPE_LAT = 4,
  parameter int FCNT_W   = 16
) (
  input  wire logic                ACLK,
  input  wire logic                ARESET,
  input  wire logic                cfg_enable,
  input  wire logic                cfg_bypass,
  input  wire logic [DIM_W-1:0]    cfg_width,
  input  wire logic [DIM_W-1:0]    cfg_height,
  input  wire logic [GAIN_W-1:0]   cfg_gain,
  input  wire logic                err_clr,
  edge_enhance_frame_ctrl_if.slave s_axis,
  input  wire logic                pipe_ready,
  output logic                     pipe_en,
  output logic [DIM_W-1:0]         col_cnt,
  output logic [DIM_W-1:0]         row_cnt,
  output logic                     win_valid,
  output logic                     pipe_flush,
  output logic [GAIN_W-1:0]        gain_q,
  output logic                     bypass_q,
  output logic                     frame_done,
  output logic                     busy,
  output logic [FCNT_W-1:0]        sts_frame_cnt,
  output logic [3:0]               sts_err
);

  localparam int FL_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(PIPE_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_SOF = 2'd1,
    S_ACTIVE   = 2'd2,
    S_FLUSH    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DIM_W-1:0]    col_q, col_d;
  logic [DIM_W-1:0]    row_q, row_d;
  logic [DIM_W-1:0]    width_q, width_d;
  logic [DIM_W-1:0]    height_q, height_d;
  logic [GAIN_W-1:0]   gain_d;
  logic                bypass_d;
  logic [FL_W-1:0]     flush_q, flush_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [3:0]          err_q, err_d;

  logic                tready;
  logic                restart;
  logic                at_end;
  logic [3:0]          new_err;
  logic [DIM_W-1:0]    pcol, prow, pw, ph;

  // Next-state, pixel position and error computation for the current cycle
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    width_d  = width_q;
    height_d = height_q;
    gain_d   = gain_q;
    bypass_d = bypass_q;
    flush_d  = flush_q;
    fcnt_d   = fcnt_q;
    new_err  = 4'b0000;
    tready   = 1'b0;
    pipe_en  = 1'b0;
    restart  = 1'b0;
    at_end   = 1'b0;
    pcol     = col_q;
    prow     = row_q;
    pw       = width_q;
    ph       = height_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_enable) begin
          if ((cfg_width >= DIM_W'(3)) && (cfg_height >= DIM_W'(3))) begin
            state_d = S_WAIT_SOF;
          end else begin
            new_err[3] = 1'b1;
          end
        end
      end
      S_WAIT_SOF: begin
        tready = 1'b1;
        // Disable takes priority; otherwise only an SOF pixel opens a frame
        if (!cfg_enable) begin
          state_d = S_IDLE;
        end else if (s_axis.s_tvalid && s_axis.s_tuser) begin
          pipe_en = 1'b1;
          restart = 1'b1;
        end
      end
      S_ACTIVE: begin
        tready = pipe_ready;
        if (s_axis.s_tvalid && pipe_ready) begin
          pipe_en = 1'b1;
          // SOF anywhere but the origin is a framing error and restarts the frame
          if (s_axis.s_tuser && ((col_q != '0) || (row_q != '0))) begin
            restart    = 1'b1;
            new_err[2] = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        flush_d = flush_q + FL_W'(1);
        if (flush_q == FL_LAST) begin
          flush_d = '0;
          fcnt_d  = fcnt_q + FCNT_W'(1);
          state_d = cfg_enable ? S_WAIT_SOF : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A (re)started frame treats this pixel as the origin under fresh config
    if (restart) begin
      pcol     = '0;
      prow     = '0;
      pw       = cfg_width;
      ph       = cfg_height;
      width_d  = cfg_width;
      height_d = cfg_height;
      gain_d   = cfg_gain;
      bypass_d = cfg_bypass;
    end

    if (pipe_en) begin
      at_end = (pcol == pw - DIM_W'(1));
      if (s_axis.s_tlast && !at_end) new_err[0] = 1'b1;
      if (at_end && !s_axis.s_tlast) new_err[1] = 1'b1;
      if (s_axis.s_tlast || at_end) begin
        col_d = '0;
        if (prow == ph - DIM_W'(1)) begin
          row_d   = '0;
          flush_d = '0;
          state_d = S_FLUSH;
        end else begin
          row_d   = prow + DIM_W'(1);
          state_d = S_ACTIVE;
        end
      end else begin
        col_d   = pcol + DIM_W'(1);
        row_d   = prow;
        state_d = S_ACTIVE;
      end
    end

    // A fresh error in the same cycle as a clear keeps its bit set
    err_d = (err_q & ~{4{err_clr}}) | new_err;
  end

  // State and shadow registers with synchronous reset
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      width_q  <= '0;
      height_q <= '0;
      gain_q   <= '0;
      bypass_q <= 1'b0;
      flush_q  <= '0;
      fcnt_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      width_q  <= width_d;
      height_q <= height_d;
      gain_q   <= gain_d;
      bypass_q <= bypass_d;
      flush_q  <= flush_d;
      fcnt_q   <= fcnt_d;
      err_q    <= err_d;
    end
  end

  assign s_axis.s_tready = tready;
  assign col_cnt         = pcol;
  assign row_cnt         = prow;
  assign win_valid       = pipe_en && (pcol >= DIM_W'(2)) && (prow >= DIM_W'(2));
  assign pipe_flush      = (state_q == S_FLUSH);
  assign frame_done      = (state_q == S_FLUSH) && (flush_q == FL_LAST);
  assign busy            = (state_q != S_IDLE);
  assign sts_frame_cnt   = fcnt_q;
  assign sts_err         = err_q;

endmodule
`default_nettype wire
